// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with saturating direction counters
// and a one-set-per-cycle flush sequencer.
module btb_assoc #(
  parameter int unsigned Sets    = 512,
  parameter int unsigned Ways    = 2,
  parameter int unsigned CtrBits = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] alt_address_i,
  input  logic        is_branch_i,
  input  logic        is_taken_i,
  input  logic        flush_req_i,
  output logic        hit_o,
  output logic        pred_taken_o,
  output logic [31:0] alt_pc_o,
  output logic        flush_busy_o
);

  localparam int unsigned Idx  = $clog2(Sets);
  localparam int unsigned WayW = (Ways > 1) ? $clog2(Ways) : 1;
  localparam int unsigned TagW = 32 - Idx - 2;
  localparam logic [CtrBits-1:0] CtrMax  = '1;
  localparam logic [CtrBits-1:0] CtrInit = CtrBits'(1) << (CtrBits - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  logic                valid_q [Sets][Ways];
  logic [TagW-1:0]     tag_q   [Sets][Ways];
  logic [31:0]         tgt_q   [Sets][Ways];
  logic [CtrBits-1:0]  ctr_q   [Sets][Ways];

  state_e              state_q, state_d;
  logic [Idx-1:0]      fidx_q, fidx_d;
  logic                flush_busy;

  logic [Idx-1:0]      if_idx, id_idx;
  logic [TagW-1:0]     if_tag, id_tag;
  logic                lk_hit, id_hit, free_found;
  logic [WayW-1:0]     lk_way, id_way, free_way, victim, alloc_way;
  logic                train_en, upd_hit, alloc, vic_adv;
  logic [CtrBits-1:0]  ctr_cur, ctr_nxt;
  logic                unused_pc_bits;

  assign if_idx = if_pc_i[Idx+1:2];
  assign if_tag = if_pc_i[31:Idx+2];
  assign id_idx = id_pc_i[Idx+1:2];
  assign id_tag = id_pc_i[31:Idx+2];
  assign unused_pc_bits = ^{if_pc_i[1:0], id_pc_i[1:0]};

  assign flush_busy   = (state_q == StFlush);
  assign flush_busy_o = flush_busy;

  // Descending scan so the lowest matching / free way is the one left selected.
  always_comb begin
    lk_hit     = 1'b0;
    lk_way     = '0;
    id_hit     = 1'b0;
    id_way     = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = int'(Ways) - 1; w >= 0; w--) begin
      if (valid_q[if_idx][w] && (tag_q[if_idx][w] == if_tag)) begin
        lk_hit = 1'b1;
        lk_way = WayW'(w);
      end
      if (valid_q[id_idx][w] && (tag_q[id_idx][w] == id_tag)) begin
        id_hit = 1'b1;
        id_way = WayW'(w);
      end
      if (!valid_q[id_idx][w]) begin
        free_found = 1'b1;
        free_way   = WayW'(w);
      end
    end
  end

  assign hit_o        = lk_hit & ~flush_busy;
  assign pred_taken_o = hit_o & ctr_q[if_idx][lk_way][CtrBits-1];
  assign alt_pc_o     = hit_o ? tgt_q[if_idx][lk_way] : 32'h0;

  assign train_en  = is_branch_i & ~stall_i & ~flush_busy & ~flush_req_i;
  assign upd_hit   = train_en & id_hit;
  assign alloc     = train_en & ~id_hit & is_taken_i;
  assign vic_adv   = alloc & ~free_found;
  assign alloc_way = free_found ? free_way : victim;
  assign ctr_cur   = ctr_q[id_idx][id_way];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (is_taken_i) begin
      if (ctr_cur != CtrMax) ctr_nxt = ctr_cur + CtrBits'(1);
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - CtrBits'(1);
    end
  end

  if (Ways > 1) begin : g_vic
    logic [WayW-1:0] vic_q [Sets];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s < int'(Sets); s++) vic_q[s] <= '0;
      end else if (flush_busy) begin
        vic_q[fidx_q] <= '0;
      end else if (vic_adv) begin
        // Ways is a power of two, so natural wrap gives the modulo.
        vic_q[id_idx] <= vic_q[id_idx] + WayW'(1);
      end
    end

    assign victim = vic_q[id_idx];
  end else begin : g_no_vic
    assign victim = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(Sets); s++) begin
        for (int w = 0; w < int'(Ways); w++) valid_q[s][w] <= 1'b0;
      end
    end else if (flush_busy) begin
      for (int w = 0; w < int'(Ways); w++) valid_q[fidx_q][w] <= 1'b0;
    end else if (alloc) begin
      valid_q[id_idx][alloc_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (upd_hit) begin
      ctr_q[id_idx][id_way] <= ctr_nxt;
      if (is_taken_i) tgt_q[id_idx][id_way] <= alt_address_i;
    end else if (alloc) begin
      tag_q[id_idx][alloc_way] <= id_tag;
      tgt_q[id_idx][alloc_way] <= alt_address_i;
      ctr_q[id_idx][alloc_way] <= CtrInit;
    end
  end

  always_comb begin
    state_d = state_q;
    fidx_d  = fidx_q;
    unique case (state_q)
      StIdle: begin
        if (flush_req_i) state_d = StFlush;
      end
      StFlush: begin
        fidx_d = fidx_q + Idx'(1);
        if (fidx_q == Idx'(Sets - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed testbench for btb_assoc (512 sets, 2 ways, 2-bit counters).
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] if_pc;
  logic [31:0] id_pc;
  logic [31:0] alt_address;
  logic        is_branch;
  logic        is_taken;
  logic        flush_req;
  logic        hit;
  logic        pred_taken;
  logic [31:0] alt_pc;
  logic        flush_busy;

  int checks = 0;
  int errors = 0;

  btb_assoc #(
    .Sets   (512),
    .Ways   (2),
    .CtrBits(2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .stall_i      (stall),
    .if_pc_i      (if_pc),
    .id_pc_i      (id_pc),
    .alt_address_i(alt_address),
    .is_branch_i  (is_branch),
    .is_taken_i   (is_taken),
    .flush_req_i  (flush_req),
    .hit_o        (hit),
    .pred_taken_o (pred_taken),
    .alt_pc_o     (alt_pc),
    .flush_busy_o (flush_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    stall       = 1'b0;
    if_pc       = 32'h0;
    id_pc       = 32'h0;
    alt_address = 32'h0;
    is_branch   = 1'b0;
    is_taken    = 1'b0;
    flush_req   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] alt, input logic taken);
    id_pc       = pc;
    alt_address = alt;
    is_taken    = taken;
    is_branch   = 1'b1;
    @(posedge clk);
    #1;
    is_branch = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    look(32'h0040_0100);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL reset_hit: got %b want 0", hit); end
    checks++; if (pred_taken !== 1'b0) begin errors++;
      $display("FAIL reset_pred: got %b want 0", pred_taken); end
    checks++; if (alt_pc !== 32'h0) begin errors++;
      $display("FAIL reset_alt: got %h want 00000000", alt_pc); end
    checks++; if (flush_busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", flush_busy); end
  endtask

  task automatic test_train_hit();
    do_reset();
    if_pc       = 32'h0040_0100;
    id_pc       = 32'h0040_0100;
    alt_address = 32'h0040_0200;
    is_taken    = 1'b1;
    is_branch   = 1'b1;
    #1;
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL same_cycle_hit: got %b want 0", hit); end
    @(posedge clk);
    #1;
    is_branch = 1'b0;
    #1;
    checks++; if (hit !== 1'b1) begin errors++;
      $display("FAIL train_hit: got %b want 1", hit); end
    checks++; if (pred_taken !== 1'b1) begin errors++;
      $display("FAIL train_pred: got %b want 1", pred_taken); end
    checks++; if (alt_pc !== 32'h0040_0200) begin errors++;
      $display("FAIL train_alt: got %h want 00400200", alt_pc); end
  endtask

  task automatic test_replace();
    do_reset();
    train(32'h0040_0100, 32'h0050_0100, 1'b1);
    train(32'h0040_0900, 32'h0050_0900, 1'b1);
    train(32'h0040_1100, 32'h0050_1100, 1'b1);
    look(32'h0040_0100);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL evict_first: hit %b want 0", hit); end
    look(32'h0040_0900);
    checks++; if (hit !== 1'b1 || alt_pc !== 32'h0050_0900) begin errors++;
      $display("FAIL keep_0900: hit %b alt %h want 1 00500900", hit, alt_pc); end
    look(32'h0040_1100);
    checks++; if (hit !== 1'b1 || alt_pc !== 32'h0050_1100) begin errors++;
      $display("FAIL keep_1100: hit %b alt %h want 1 00501100", hit, alt_pc); end
    // Pointer advanced to way 1 on the first eviction, so 0x00400900 goes next.
    train(32'h0040_1900, 32'h0050_1900, 1'b1);
    look(32'h0040_0900);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL evict_second: hit %b want 0", hit); end
    look(32'h0040_1100);
    checks++; if (hit !== 1'b1 || alt_pc !== 32'h0050_1100) begin errors++;
      $display("FAIL keep_1100_b: hit %b alt %h want 1 00501100", hit, alt_pc); end
    look(32'h0040_1900);
    checks++; if (hit !== 1'b1 || alt_pc !== 32'h0050_1900) begin errors++;
      $display("FAIL new_1900: hit %b alt %h want 1 00501900", hit, alt_pc); end
    train(32'h0040_2100, 32'h0050_2100, 1'b0);
    look(32'h0040_2100);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL miss_not_taken: hit %b want 0", hit); end
  endtask

  task automatic test_counter();
    logic        dir  [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    logic        epred[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    logic [31:0] ealt;
    logic [31:0] a;
    do_reset();
    ealt = 32'h0;
    for (int i = 0; i < 9; i++) begin
      a = dir[i] ? (32'h0050_0000 + 32'(i * 16)) : 32'hDEAD_0000;
      if (dir[i]) ealt = a;
      train(32'h0040_2000, a, dir[i]);
      look(32'h0040_2000);
      checks++;
      if (hit !== 1'b1 || pred_taken !== epred[i] || alt_pc !== ealt) begin
        errors++;
        $display("FAIL ctr_step%0d: hit %b pred %b alt %h want 1 %b %h",
                 i, hit, pred_taken, alt_pc, epred[i], ealt);
      end
    end
  endtask

  task automatic test_flush();
    int cnt;
    int bad;
    do_reset();
    train(32'h0040_0100, 32'h0060_0100, 1'b1);
    train(32'h0040_0204, 32'h0060_0204, 1'b1);
    train(32'h0040_0308, 32'h0060_0308, 1'b1);
    look(32'h0040_0204);
    checks++; if (hit !== 1'b1) begin errors++;
      $display("FAIL pre_flush_hit: hit %b want 1", hit); end
    // Flush request and training in the same cycle: training must be dropped.
    id_pc       = 32'h0040_3000;
    alt_address = 32'h0060_3000;
    is_taken    = 1'b1;
    is_branch   = 1'b1;
    flush_req   = 1'b1;
    if_pc       = 32'h0040_0100;
    #1;
    checks++; if (flush_busy !== 1'b0 || hit !== 1'b1) begin errors++;
      $display("FAIL req_cycle: busy %b hit %b want 0 1", flush_busy, hit); end
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (!flush_busy) break;
      cnt++;
      if (hit !== 1'b0 || pred_taken !== 1'b0 || alt_pc !== 32'h0) bad++;
      flush_req = (i == 10);
      @(posedge clk);
      #1;
    end
    is_branch = 1'b0;
    flush_req = 1'b0;
    checks++; if (cnt !== 512) begin errors++;
      $display("FAIL flush_len: got %0d cycles want 512", cnt); end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL flush_outputs: %0d busy cycles with nonzero outputs, want 0", bad); end
    look(32'h0040_0100);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL post_flush_0100: hit %b want 0", hit); end
    look(32'h0040_0204);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL post_flush_0204: hit %b want 0", hit); end
    look(32'h0040_0308);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL post_flush_0308: hit %b want 0", hit); end
    look(32'h0040_3000);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL flush_train_dropped: hit %b want 0", hit); end
  endtask

  task automatic test_stall_reset();
    int cnt;
    do_reset();
    train(32'h0040_0100, 32'h0070_0100, 1'b1);
    stall = 1'b1;
    train(32'h0040_0100, 32'h0070_9999, 1'b1);
    train(32'h0040_4000, 32'h0070_4000, 1'b1);
    stall = 1'b0;
    look(32'h0040_0100);
    checks++; if (hit !== 1'b1 || alt_pc !== 32'h0070_0100) begin errors++;
      $display("FAIL stall_keep: hit %b alt %h want 1 00700100", hit, alt_pc); end
    look(32'h0040_4000);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL stall_no_alloc: hit %b want 0", hit); end
    look(32'h0040_0100);
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
    end
    checks++; if (flush_busy !== 1'b1) begin errors++;
      $display("FAIL mid_flush_busy: got %b want 1", flush_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (flush_busy !== 1'b0 || hit !== 1'b0 || alt_pc !== 32'h0) begin errors++;
      $display("FAIL async_reset: busy %b hit %b alt %h want 0 0 0", flush_busy, hit, alt_pc);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (hit !== 1'b0 || flush_busy !== 1'b0) begin errors++;
      $display("FAIL after_reset: hit %b busy %b want 0 0", hit, flush_busy); end
    train(32'h0040_0204, 32'h0070_0204, 1'b1);
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!flush_busy) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    checks++; if (cnt !== 512) begin errors++;
      $display("FAIL reflush_len: got %0d cycles want 512", cnt); end
    look(32'h0040_0204);
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL reflush_miss: hit %b want 0", hit); end
  endtask

  initial begin
    test_reset();
    test_train_hit();
    test_replace();
    test_counter();
    test_flush();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
